// File: rtl/board_renderer.sv
// board_renderer: colours one VGA pixel per pix_tick for a 10x20 cell playfield.
// The settled-board row under the beam is fetched once per line into a line
// buffer. The active piece is drawn from a shadow copy that is taken at frame
// start. Row and column positions come from wrap-around counters, so no
// divider is needed.
module board_renderer #(
    parameter int          X0        = 220,
    parameter int          Y0        = 20,
    parameter int          CELL      = 22,
    parameter logic [11:0] C_BG      = 12'hF70,
    parameter logic [11:0] C_EMPTY   = 12'h000,
    parameter logic [11:0] C_GRID    = 12'h222,
    parameter logic [11:0] C_SETTLED = 12'h888,
    parameter logic [11:0] C_PIECE   = 12'h0FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_tick,
    input  logic [9:0]  x_vga,
    input  logic [9:0]  y_vga,
    input  logic [3:0]  x1,
    input  logic [3:0]  x2,
    input  logic [3:0]  x3,
    input  logic [3:0]  x4,
    input  logic [4:0]  y1,
    input  logic [4:0]  y2,
    input  logic [4:0]  y3,
    input  logic [4:0]  y4,
    input  logic        piece_valid,
    output logic        row_rd,
    output logic [4:0]  row_addr,
    input  logic [9:0]  row_data,
    output logic [11:0] color
);

    localparam logic [9:0] X_LO     = 10'(X0);
    localparam logic [9:0] X_HI     = 10'(X0 + 10 * CELL);
    localparam logic [9:0] Y_LO     = 10'(Y0);
    localparam logic [9:0] Y_HI     = 10'(Y0 + 20 * CELL);
    localparam logic [4:0] OFF_LAST = 5'(CELL - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

    state_t      state;
    logic [9:0]  line_buf;
    logic [4:0]  row_idx, row_off, row_idx_n, row_off_n;
    logic [3:0]  col_idx, col_idx_n;
    logic [4:0]  col_off, col_off_n;
    logic [3:0]  sh_x1, sh_x2, sh_x3, sh_x4;
    logic [4:0]  sh_y1, sh_y2, sh_y3, sh_y4;
    logic        sh_valid;
    logic        line_start, frame_start, in_x, in_y;
    logic        piece_hit, settled;
    logic [15:0] line_ext;
    logic [11:0] pix_color;

    // An in-cell offset of CELL-1 marks the grid pixel. The next pixel starts a new cell.
    function automatic logic [4:0] off_step(input logic [4:0] off);
        return (off == OFF_LAST) ? 5'd0 : off + 5'd1;
    endfunction

    assign line_start  = pix_tick && (x_vga == 10'd0);
    assign frame_start = line_start && (y_vga == 10'd0);
    assign in_x        = (x_vga >= X_LO) && (x_vga < X_HI);
    assign in_y        = (y_vga >= Y_LO) && (y_vga < Y_HI);

    // Next row position: restart on the board's top line, else step once per line
    always_comb begin
        row_idx_n = row_idx;
        row_off_n = row_off;
        if (line_start) begin
            if (y_vga == Y_LO) begin
                row_idx_n = 5'd0;
                row_off_n = 5'd0;
            end else begin
                row_off_n = off_step(row_off);
                if (row_off == OFF_LAST) row_idx_n = row_idx + 5'd1;
            end
        end
    end

    // Next column position: restart on the board's left pixel, else step per tick
    always_comb begin
        col_idx_n = col_idx;
        col_off_n = col_off;
        if (pix_tick) begin
            if (x_vga == X_LO) begin
                col_idx_n = 4'd0;
                col_off_n = 5'd0;
            end else begin
                col_off_n = off_step(col_off);
                if (col_off == OFF_LAST) col_idx_n = col_idx + 4'd1;
            end
        end
    end

    assign piece_hit = sh_valid && (((sh_x1 == col_idx_n) && (sh_y1 == row_idx_n)) ||
                                    ((sh_x2 == col_idx_n) && (sh_y2 == row_idx_n)) ||
                                    ((sh_x3 == col_idx_n) && (sh_y3 == row_idx_n)) ||
                                    ((sh_x4 == col_idx_n) && (sh_y4 == row_idx_n)));
    assign line_ext  = {6'd0, line_buf};
    assign settled   = line_ext[col_idx_n];

    // Colour priority for the pixel under the beam
    always_comb begin
        pix_color = C_EMPTY;
        if (!(in_x && in_y))
            pix_color = C_BG;
        else if ((col_off_n == OFF_LAST) || (row_off_n == OFF_LAST))
            pix_color = C_GRID;
        else if (piece_hit)
            pix_color = C_PIECE;
        else if (settled)
            pix_color = C_SETTLED;
    end

    // Position counters advance only with pixel ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx <= 5'd0;
            row_off <= 5'd0;
            col_idx <= 4'd0;
            col_off <= 5'd0;
        end else begin
            row_idx <= row_idx_n;
            row_off <= row_off_n;
            col_idx <= col_idx_n;
            col_off <= col_off_n;
        end
    end

    // Row fetch: one read strobe per board line, data captured one clk later
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row_rd   <= 1'b0;
            row_addr <= 5'd0;
            line_buf <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_start) begin
                        if (in_y) begin
                            state    <= FETCH;
                            row_rd   <= 1'b1;
                            row_addr <= row_idx_n;
                        end else begin
                            line_buf <= 10'd0;
                        end
                    end
                end
                FETCH: begin
                    row_rd <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    line_buf <= row_data;
                    state    <= IDLE;
                end
                default: begin
                    row_rd <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Piece shadow taken at frame start so mid-frame moves never tear the image
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_valid <= 1'b0;
            sh_x1 <= 4'd0; sh_x2 <= 4'd0; sh_x3 <= 4'd0; sh_x4 <= 4'd0;
            sh_y1 <= 5'd0; sh_y2 <= 5'd0; sh_y3 <= 5'd0; sh_y4 <= 5'd0;
        end else if (frame_start) begin
            sh_valid <= piece_valid;
            sh_x1 <= x1; sh_x2 <= x2; sh_x3 <= x3; sh_x4 <= x4;
            sh_y1 <= y1; sh_y2 <= y2; sh_y3 <= y3; sh_y4 <= y4;
        end
    end

    // Output colour register, held between pixel ticks
    always_ff @(posedge clk) begin
        if (reset)
            color <= 12'd0;
        else if (pix_tick)
            color <= pix_color;
    end

endmodule
